// File: rtl/fx3_seq_pkg.sv
// Shared definitions for the FX3 slave-FIFO write sequencer.
//   SKID_W        : skid FIFO entry width (8 data bits + buffer-end tag in the MSB)
//   FX3_PKT_BYTES : default FX3 DMA buffer size in bytes
//   ST_*          : sequencer state encodings
package fx3_seq_pkg;

    localparam int unsigned SKID_W        = 9;
    localparam int unsigned FX3_PKT_BYTES = 512;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_ARM    = 3'd1;
    localparam state_t ST_STREAM = 3'd2;
    localparam state_t ST_HOLD   = 3'd3;
    localparam state_t ST_CLOSE  = 3'd4;

endpackage

// File: rtl/fx3_skid_fifo.sv
// Small synchronous FIFO that absorbs the loader's pause latency.
// Same-cycle push and pop are allowed; empty/full/count are registered.
// A push while full with no pop is dropped (the parent flags it as an error).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_data     : write request and entry
//   pop, pop_data       : read request and head entry (valid while !empty)
//   empty, full, count  : registered occupancy status
module fx3_skid_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == FULL_LVL);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fx3_slfifo_write_sequencer.sv
// Streams loader bytes into the FX3 GPIF-II synchronous slave FIFO (8-bit,
// write-only), splitting traffic into PKT_BYTES packets and closing short
// packets at loader buffer ends. Everything runs on fx3_clk.
// Optional feature: define FX3_ZLP_EN to follow a buffer end that lands exactly
// on a packet boundary with a zero-length packet.
// Ports:
//   fx3_clk, fx3_rst_n      : clock, asynchronous active-low reset
//   enable                  : level; low = drain, close packet, go idle
//   ld_ready, ld_pause      : loader handshake outputs
//   ld_vld, ld_data         : loader byte stream
//   ld_buf_end              : marks the last byte of a loader buffer
//   flaga_n, flagb_n        : FX3 full / watermark flags (active-low)
//   slcs_n, slwr_n, pktend_n: FX3 strobes (active-low)
//   fifo_addr, fx3_dq       : socket address and write data
//   pkt_cnt                 : committed-packet counter
module fx3_slfifo_write_sequencer
    import fx3_seq_pkg::*;
#(
    parameter int unsigned PKT_BYTES  = FX3_PKT_BYTES,
    parameter int unsigned FLAG_LAT   = 3,
    parameter int unsigned SKID_DEPTH = 4,
    parameter logic [1:0]  FIFO_ADDR  = 2'd0
) (
    input  logic        fx3_clk,
    input  logic        fx3_rst_n,
    input  logic        enable,
    output logic        ld_ready,
    output logic        ld_pause,
    input  logic        ld_vld,
    input  logic [7:0]  ld_data,
    input  logic        ld_buf_end,
    input  logic        flaga_n,
    input  logic        flagb_n,
    output logic        slcs_n,
    output logic        slwr_n,
    output logic        pktend_n,
    output logic [1:0]  fifo_addr,
    output logic [7:0]  fx3_dq,
    output logic [31:0] pkt_cnt
);

    localparam int unsigned BC_W = $clog2(PKT_BYTES);
    localparam int unsigned QW   = $clog2(FLAG_LAT) + 1;
    localparam int unsigned CW   = $clog2(SKID_DEPTH) + 1;
    localparam logic [QW-1:0] QUAL_LAST = QW'(FLAG_LAT - 1);
    localparam logic [CW-1:0] PAUSE_LVL = CW'(SKID_DEPTH - 2);

    state_t            state;
    state_t            state_nxt;
    logic [QW-1:0]     qual_cnt;
    logic              flag_ok;
    logic [BC_W-1:0]   byte_cnt;
    logic              skid_empty;
    logic              skid_full;
    logic [CW-1:0]     skid_count;
    logic [SKID_W-1:0] skid_dout;
    logic              pop;
    logic              tag;
    logic              wrap;
    logic              short_end;
    logic              close_end;
    logic              can_close;
    logic              zlp_pend;

    fx3_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (SKID_W)
    ) u_skid (
        .clk       (fx3_clk),
        .rst_n     (fx3_rst_n),
        .push      (ld_vld),
        .push_data ({ld_buf_end, ld_data}),
        .pop       (pop),
        .pop_data  (skid_dout),
        .empty     (skid_empty),
        .full      (skid_full),
        .count     (skid_count)
    );

    assign fifo_addr = FIFO_ADDR;

    // Flag is trusted only after FLAG_LAT consecutive high samples.
    assign flag_ok   = flagb_n && (qual_cnt == QUAL_LAST);
    assign tag       = skid_dout[SKID_W-1];
    assign wrap      = (byte_cnt == '1);
    // A pending ZLP reserves the next write slot, so popping is held off.
    assign pop       = (state == ST_STREAM) && flaga_n && flagb_n && !skid_empty && !zlp_pend;
    assign short_end = pop && tag && !wrap;
    assign close_end = (state == ST_CLOSE) && (byte_cnt != '0);
    assign can_close = !enable && skid_empty && !ld_vld;
    assign ld_pause  = (skid_count >= PAUSE_LVL) || (state != ST_STREAM);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (enable) state_nxt = ST_ARM;
            ST_ARM: begin
                if (!enable)      state_nxt = ST_IDLE;
                else if (flag_ok) state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (can_close)     state_nxt = ST_CLOSE;
                else if (!flagb_n) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (can_close)    state_nxt = ST_CLOSE;
                else if (flag_ok) state_nxt = ST_STREAM;
            end
            ST_CLOSE:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge fx3_clk or negedge fx3_rst_n) begin
        if (!fx3_rst_n) begin
            state    <= ST_IDLE;
            qual_cnt <= '0;
            byte_cnt <= '0;
            pkt_cnt  <= '0;
            slcs_n   <= 1'b1;
            slwr_n   <= 1'b1;
            pktend_n <= 1'b1;
            fx3_dq   <= '0;
            ld_ready <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!flagb_n || (state == ST_IDLE)) begin
                qual_cnt <= '0;
            end else if (qual_cnt != QUAL_LAST) begin
                qual_cnt <= qual_cnt + 1'b1;
            end
            slwr_n   <= !pop;
            pktend_n <= !(short_end || close_end || zlp_pend);
            if (pop) fx3_dq <= skid_dout[7:0];
            if (short_end || close_end) begin
                byte_cnt <= '0;
            end else if (pop) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
            if ((pop && (wrap || tag)) || close_end || zlp_pend) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
            ld_ready <= (state_nxt == ST_STREAM) || (state_nxt == ST_HOLD);
            // Chip select stays low through the CLOSE pktend pulse.
            slcs_n   <= (state_nxt == ST_IDLE) && (state != ST_CLOSE);
        end
    end

`ifdef FX3_ZLP_EN
    always_ff @(posedge fx3_clk or negedge fx3_rst_n) begin
        if (!fx3_rst_n) begin
            zlp_pend <= 1'b0;
        end else begin
            zlp_pend <= pop && tag && wrap;
        end
    end
`else
    assign zlp_pend = 1'b0;
`endif

    a_skid_no_overflow: assert property (@(posedge fx3_clk) disable iff (!fx3_rst_n)
        !(ld_vld && skid_full && !pop));

    a_no_write_when_full: assert property (@(posedge fx3_clk) disable iff (!fx3_rst_n)
        !(!slwr_n && !flaga_n));

endmodule

// File: tb/tb_fx3_slfifo_write_sequencer.sv
// Directed bench for fx3_slfifo_write_sequencer: drives a zero-latency loader
// model, logs every FX3 write and pktend strobe, and compares against
// hand-computed packet/byte expectations. Builds with or without FX3_ZLP_EN.
`timescale 1ns/1ps
module tb_fx3_slfifo_write_sequencer;

`ifdef FX3_ZLP_EN
    localparam int unsigned ZLP = 1;
`else
    localparam int unsigned ZLP = 0;
`endif
    localparam int unsigned FLAG_LAT = 3;

    logic        fx3_clk    = 1'b0;
    logic        fx3_rst_n  = 1'b1;
    logic        enable     = 1'b0;
    logic        ld_vld     = 1'b0;
    logic [7:0]  ld_data    = '0;
    logic        ld_buf_end = 1'b0;
    logic        flaga_n    = 1'b1;
    logic        flagb_n    = 1'b1;
    logic        ld_ready;
    logic        ld_pause;
    logic        slcs_n;
    logic        slwr_n;
    logic        pktend_n;
    logic [1:0]  fifo_addr;
    logic [7:0]  fx3_dq;
    logic [31:0] pkt_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0]  wr_log [4096];
    int unsigned n_wr         = 0;
    int unsigned pe_wr        = 0;
    int unsigned pe_wr_idx    = 0;
    int unsigned pe_alone     = 0;
    int unsigned pe_alone_idx = 0;

    fx3_slfifo_write_sequencer #(
        .PKT_BYTES  (512),
        .FLAG_LAT   (FLAG_LAT),
        .SKID_DEPTH (4),
        .FIFO_ADDR  (2'd0)
    ) dut (
        .fx3_clk    (fx3_clk),
        .fx3_rst_n  (fx3_rst_n),
        .enable     (enable),
        .ld_ready   (ld_ready),
        .ld_pause   (ld_pause),
        .ld_vld     (ld_vld),
        .ld_data    (ld_data),
        .ld_buf_end (ld_buf_end),
        .flaga_n    (flaga_n),
        .flagb_n    (flagb_n),
        .slcs_n     (slcs_n),
        .slwr_n     (slwr_n),
        .pktend_n   (pktend_n),
        .fifo_addr  (fifo_addr),
        .fx3_dq     (fx3_dq),
        .pkt_cnt    (pkt_cnt)
    );

    always #5 fx3_clk = ~fx3_clk;

    // Pin monitor, sampled on the inactive edge.
    always @(negedge fx3_clk) begin
        if (!slwr_n) begin
            wr_log[n_wr % 4096] = fx3_dq;
            n_wr = n_wr + 1;
        end
        if (!pktend_n) begin
            if (!slwr_n) begin
                pe_wr     = pe_wr + 1;
                pe_wr_idx = n_wr;
            end else begin
                pe_alone     = pe_alone + 1;
                pe_alone_idx = n_wr;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_buf(input int unsigned n, input int unsigned seed,
                            input logic tag_last, input string tag);
        int unsigned sent  = 0;
        int unsigned guard = 0;
        while (sent < n && guard < 5000) begin
            @(negedge fx3_clk);
            guard++;
            if (ld_ready && !ld_pause) begin
                ld_vld     = 1'b1;
                ld_data    = 8'(sent + seed);
                ld_buf_end = tag_last && (sent == n - 1);
                sent++;
            end else begin
                ld_vld     = 1'b0;
                ld_buf_end = 1'b0;
            end
        end
        @(negedge fx3_clk);
        ld_vld     = 1'b0;
        ld_buf_end = 1'b0;
        check_eq(tag, sent, n);
    endtask

    task automatic wait_writes(input int unsigned base, input int unsigned n);
        int unsigned guard = 0;
        while ((n_wr - base) < n && guard < 3000) begin
            @(negedge fx3_clk);
            guard++;
        end
        repeat (12) @(negedge fx3_clk);
    endtask

    function automatic int unsigned data_errs(input int unsigned base, input int unsigned n,
                                              input int unsigned seed);
        int unsigned errs = 0;
        for (int unsigned i = 0; i < n; i++) begin
            if (wr_log[(base + i) % 4096] !== 8'(i + seed)) errs++;
        end
        return errs;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned b_wr;
        int unsigned b_pw;
        int unsigned b_pa;
        int unsigned g;
        int unsigned hold_wr;
        int unsigned hold_unpaused;
        int unsigned resume_gap;
        logic [31:0] exp_pkts;

        exp_pkts = 0;
        #2 fx3_rst_n = 1'b0;
        repeat (3) @(negedge fx3_clk);
        check_eq("rst_slcs_n",    32'(slcs_n),    32'd1);
        check_eq("rst_slwr_n",    32'(slwr_n),    32'd1);
        check_eq("rst_pktend_n",  32'(pktend_n),  32'd1);
        check_eq("rst_fx3_dq",    32'(fx3_dq),    32'd0);
        check_eq("rst_ld_ready",  32'(ld_ready),  32'd0);
        check_eq("rst_ld_pause",  32'(ld_pause),  32'd1);
        check_eq("rst_pkt_cnt",   pkt_cnt,        32'd0);
        check_eq("rst_fifo_addr", 32'(fifo_addr), 32'd0);
        fx3_rst_n = 1'b1;
        @(negedge fx3_clk);
        enable = 1'b1;

        // 1024-byte buffer: two full packets, auto-committed
        b_wr = n_wr; b_pw = pe_wr; b_pa = pe_alone;
        send_buf(1024, 0, 1'b1, "t1_sent");
        wait_writes(b_wr, 1024);
        check_eq("t1_writes", n_wr - b_wr, 1024);
        check_eq("t1_data_errs", data_errs(b_wr, 1024, 0), 0);
        check_eq("t1_pktend_with_wr", pe_wr - b_pw, 0);
        check_eq("t1_pktend_alone", pe_alone - b_pa, ZLP);
        exp_pkts = exp_pkts + 2 + ZLP;
        check_eq("t1_pkt_cnt", pkt_cnt, exp_pkts);
        check_eq("t1_ld_ready", 32'(ld_ready), 32'd1);
        check_eq("t1_slcs_n", 32'(slcs_n), 32'd0);

        // 700-byte buffer: one full packet plus a 188-byte short packet
        b_wr = n_wr; b_pw = pe_wr; b_pa = pe_alone;
        send_buf(700, 7, 1'b1, "t2_sent");
        wait_writes(b_wr, 700);
        check_eq("t2_writes", n_wr - b_wr, 700);
        check_eq("t2_data_errs", data_errs(b_wr, 700, 7), 0);
        check_eq("t2_pktend_with_wr", pe_wr - b_pw, 1);
        check_eq("t2_pktend_index", pe_wr_idx - b_wr, 700);
        check_eq("t2_pktend_alone", pe_alone - b_pa, 0);
        exp_pkts = exp_pkts + 2;
        check_eq("t2_pkt_cnt", pkt_cnt, exp_pkts);

        // Watermark hold of 20 cycles in the middle of a 300-byte buffer
        b_wr = n_wr; b_pw = pe_wr; b_pa = pe_alone;
        hold_wr = 0; hold_unpaused = 0; resume_gap = 0;
        fork
            send_buf(300, 3, 1'b1, "t3_sent");
            begin
                g = 0;
                while ((n_wr - b_wr) < 100 && g < 3000) begin
                    @(negedge fx3_clk);
                    g++;
                end
                flagb_n = 1'b0;
                repeat (20) begin
                    @(negedge fx3_clk);
                    if (!slwr_n)   hold_wr++;
                    if (!ld_pause) hold_unpaused++;
                end
                flagb_n = 1'b1;
                while (slwr_n && resume_gap < 50) begin
                    @(negedge fx3_clk);
                    resume_gap++;
                end
            end
        join
        wait_writes(b_wr, 300);
        check_eq("t3_writes", n_wr - b_wr, 300);
        check_eq("t3_data_errs", data_errs(b_wr, 300, 3), 0);
        check_eq("t3_writes_during_hold", hold_wr, 0);
        check_eq("t3_unpaused_during_hold", hold_unpaused, 0);
        check_eq("t3_resume_gap", resume_gap, FLAG_LAT + 1);
        check_eq("t3_pktend_with_wr", pe_wr - b_pw, 1);
        check_eq("t3_pktend_index", pe_wr_idx - b_wr, 300);
        exp_pkts = exp_pkts + 1;
        check_eq("t3_pkt_cnt", pkt_cnt, exp_pkts);

        // Buffer end exactly on a packet boundary
        b_wr = n_wr; b_pw = pe_wr; b_pa = pe_alone;
        send_buf(512, 11, 1'b1, "t4_sent");
        wait_writes(b_wr, 512);
        check_eq("t4_writes", n_wr - b_wr, 512);
        check_eq("t4_data_errs", data_errs(b_wr, 512, 11), 0);
        check_eq("t4_pktend_with_wr", pe_wr - b_pw, 0);
        check_eq("t4_pktend_alone", pe_alone - b_pa, ZLP);
`ifdef FX3_ZLP_EN
        check_eq("t4_zlp_index", pe_alone_idx - b_wr, 512);
`endif
        exp_pkts = exp_pkts + 1 + ZLP;
        check_eq("t4_pkt_cnt", pkt_cnt, exp_pkts);

        // Enable drops after 37 bytes of an open packet
        b_wr = n_wr; b_pw = pe_wr; b_pa = pe_alone;
        send_buf(37, 5, 1'b0, "t5_sent");
        enable = 1'b0;
        g = 0;
        while (!slcs_n && g < 200) begin
            @(negedge fx3_clk);
            g++;
        end
        repeat (3) @(negedge fx3_clk);
        check_eq("t5_writes", n_wr - b_wr, 37);
        check_eq("t5_data_errs", data_errs(b_wr, 37, 5), 0);
        check_eq("t5_pktend_alone", pe_alone - b_pa, 1);
        check_eq("t5_pktend_index", pe_alone_idx - b_wr, 37);
        check_eq("t5_pktend_with_wr", pe_wr - b_pw, 0);
        check_eq("t5_slcs_n", 32'(slcs_n), 32'd1);
        check_eq("t5_ld_ready", 32'(ld_ready), 32'd0);
        check_eq("t5_ld_pause", 32'(ld_pause), 32'd1);
        exp_pkts = exp_pkts + 1;
        check_eq("t5_pkt_cnt", pkt_cnt, exp_pkts);

        // Asynchronous reset mid-stream, then a clean restart
        @(negedge fx3_clk);
        enable = 1'b1;
        b_pw = pe_wr; b_pa = pe_alone;
        send_buf(60, 0, 1'b0, "t6_sent");
        #3 fx3_rst_n = 1'b0;
        #1;
        check_eq("t6_rst_slwr_n",   32'(slwr_n),   32'd1);
        check_eq("t6_rst_pktend_n", 32'(pktend_n), 32'd1);
        check_eq("t6_rst_slcs_n",   32'(slcs_n),   32'd1);
        check_eq("t6_rst_fx3_dq",   32'(fx3_dq),   32'd0);
        check_eq("t6_rst_pkt_cnt",  pkt_cnt,       32'd0);
        check_eq("t6_rst_ld_ready", 32'(ld_ready), 32'd0);
        check_eq("t6_rst_ld_pause", 32'(ld_pause), 32'd1);
        check_eq("t6_no_pktend", (pe_wr - b_pw) + (pe_alone - b_pa), 0);
        repeat (2) @(negedge fx3_clk);
        fx3_rst_n = 1'b1;
        exp_pkts = 0;
        b_wr = n_wr; b_pw = pe_wr; b_pa = pe_alone;
        send_buf(100, 0, 1'b1, "t6_resent");
        wait_writes(b_wr, 100);
        check_eq("t6_writes", n_wr - b_wr, 100);
        check_eq("t6_data_errs", data_errs(b_wr, 100, 0), 0);
        check_eq("t6_pktend_with_wr", pe_wr - b_pw, 1);
        check_eq("t6_pktend_index", pe_wr_idx - b_wr, 100);
        exp_pkts = exp_pkts + 1;
        check_eq("t6_pkt_cnt", pkt_cnt, exp_pkts);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
